// File: rtl/morse_pkg.sv
// Shared Morse timing, state encoding and letter constants.
// Timing defaults derive from the SOS blinker's quarter-second timebase.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOW,
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_GAP
  } state_t;

  localparam logic [4:0] S_BITS  = 5'b00000;
  localparam logic [4:0] O_BITS  = 5'b00111;
  localparam logic [2:0] LEN_S_O = 3'd3;

  localparam int QUARTER_CYC = 12_500_000;

  localparam int CNT_W_DEF      = 26;
  localparam int GLITCH_DEF     = QUARTER_CYC / 8;
  localparam int DASH_MIN_DEF   = QUARTER_CYC * 3 / 2;
  localparam int ON_MAX_DEF     = QUARTER_CYC * 4;
  localparam int LETTER_GAP_DEF = QUARTER_CYC * 2;
  localparam int WORD_GAP_DEF   = QUARTER_CYC * 4;

  // Expected letter at word position idx: S, O, S.
  // Any position past the third never matches.
  function automatic logic letter_match(
    input logic [2:0] idx,
    input logic [4:0] bits,
    input logic [2:0] len
  );
    logic ok;
    ok = 1'b0;
    unique case (idx)
      3'd0, 3'd2: ok = (bits == S_BITS) && (len == LEN_S_O);
      3'd1:       ok = (bits == O_BITS) && (len == LEN_S_O);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/morse_sos_decoder_sync.sv
// Two-flop synchronizer for one asynchronous bit.
// Ports: clk, rst_n (async low), d (async in), q (synced out); RST_VAL = reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/morse_sos_decoder.sv
// Morse receiver: times marks/spaces, assembles letters, flags S-O-S words.
// Ports: clk, rst_n, sig_in -> letter_valid/bits/len, sos_detect, err, busy.
module morse_sos_decoder
  import morse_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int GLITCH_CYC     = GLITCH_DEF,
  parameter int DASH_MIN_CYC   = DASH_MIN_DEF,
  parameter int ON_MAX_CYC     = ON_MAX_DEF,
  parameter int LETTER_GAP_CYC = LETTER_GAP_DEF,
  parameter int WORD_GAP_CYC   = WORD_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  output logic       letter_valid,
  output logic [4:0] letter_bits,
  output logic [2:0] letter_len,
  output logic       sos_detect,
  output logic       err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_CYC);
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_MIN_CYC);
  localparam logic [CNT_W-1:0] ON_MAX_C = CNT_W'(ON_MAX_CYC);
  localparam logic [CNT_W-1:0] LGAP_C   = CNT_W'(LETTER_GAP_CYC);
  localparam logic [CNT_W-1:0] WGAP_C   = CNT_W'(WORD_GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sig_s;

  // Resets high so a mark held through reset is not timed.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .q    (sig_s)
  );

  state_t           state_q, state_d;
  state_t           prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]       bits_q, bits_d;
  logic [2:0]       len_q, len_d;
  logic [2:0]       nlet_q, nlet_d;
  logic             wok_q, wok_d;
  logic [4:0]       lbits_q, lbits_d;
  logic [2:0]       llen_q, llen_d;
  logic             lv_q, lv_d;
  logic             sos_q, sos_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             is_dash;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign is_dash = (cnt_q >= DASH_C);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cnt_d   = cnt_inc;
    bits_d  = bits_q;
    len_d   = len_q;
    nlet_d  = nlet_q;
    wok_d   = wok_q;
    lbits_d = lbits_q;
    llen_d  = llen_q;
    lv_d    = 1'b0;
    sos_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_WAIT_LOW: begin
        if (!sig_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (sig_s) begin
          state_d = ST_MARK;
          prev_d  = ST_IDLE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_MARK: begin
        // cnt here is the number of high samples seen so far
        if (cnt_q >= ON_MAX_C) begin
          err_d   = 1'b1;
          bits_d  = '0;
          len_d   = '0;
          nlet_d  = '0;
          wok_d   = 1'b1;
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else if (!sig_s) begin
          cnt_d = CNT_ONE;
          if (cnt_q < GLITCH_C) begin
            state_d = prev_q;
          end else if (len_q == 3'd5) begin
            err_d   = 1'b1;
            bits_d  = '0;
            len_d   = '0;
            nlet_d  = '0;
            wok_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bits_d  = bits_q | (5'(is_dash) << len_q);
            len_d   = len_q + 3'd1;
            state_d = ST_SPACE;
          end
        end
      end
      ST_SPACE: begin
        if (sig_s) begin
          state_d = ST_MARK;
          prev_d  = ST_SPACE;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LGAP_C) begin
          lv_d    = 1'b1;
          lbits_d = bits_q;
          llen_d  = len_q;
          wok_d   = wok_q & letter_match(nlet_q, bits_q, len_q);
          nlet_d  = (nlet_q == 3'd4) ? nlet_q : nlet_q + 3'd1;
          bits_d  = '0;
          len_d   = '0;
          // cnt keeps running so the word gap includes the letter gap
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (sig_s) begin
          state_d = ST_MARK;
          prev_d  = ST_GAP;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == WGAP_C) begin
          sos_d   = wok_q && (nlet_q == 3'd3);
          nlet_d  = '0;
          wok_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_WAIT_LOW;
        cnt_d   = CNT_ONE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_LOW;
      prev_q  <= ST_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      nlet_q  <= '0;
      wok_q   <= 1'b1;
      lbits_q <= '0;
      llen_q  <= '0;
      lv_q    <= 1'b0;
      sos_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      nlet_q  <= nlet_d;
      wok_q   <= wok_d;
      lbits_q <= lbits_d;
      llen_q  <= llen_d;
      lv_q    <= lv_d;
      sos_q   <= sos_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign letter_valid = lv_q;
  assign letter_bits  = lbits_q;
  assign letter_len   = llen_q;
  assign sos_detect   = sos_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: doc/morse_sos_decoder.md
Name: morse_sos_decoder

Overview:
- Receive-side counterpart of the board's SOS LED blinker.
- Samples a single asynchronous on/off light or button signal, measures mark and space durations against the blinker's timebase, and classifies each mark as a dot (1/4 s) or a dash (1/2 s).
- Assembles up to 5 symbols per letter, emits each completed letter, and pulses sos_detect when a word is exactly S-O-S.
- Sits between a photodiode or pushbutton input pin and the status LED/debug logic on the 50 MHz eval board.

Parameters:
- CNT_W, 26, duration counter width; must hold ON_MAX_CYC.
- GLITCH_CYC, 1_562_500, marks shorter than this (cycles) are discarded as noise.
- DASH_MIN_CYC, 18_750_000, mark length at or above this is a dash; below it is a dot.
- ON_MAX_CYC, 50_000_000, mark reaching this length is an error.
- LETTER_GAP_CYC, 25_000_000, space length that closes a letter.
- WORD_GAP_CYC, 50_000_000, space length that closes a word.

Ports:
- clk  in  1  50 MHz source clock.
- rst_n  in  1  asynchronous, active-low reset.
- sig_in  in  1  raw asynchronous mark input; 1 = light on / pressed.
- letter_valid  out  1  one-cycle pulse; a letter has completed.
- letter_bits  out  5  symbol i is in bit i (first symbol = bit 0); 1 = dash. Held until the next letter.
- letter_len  out  3  symbol count 1..5, held with letter_bits.
- sos_detect  out  1  one-cycle pulse at a word end when the word was exactly S,O,S.
- err  out  1  one-cycle pulse on an over-long mark or a 6th symbol.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset:
- Async, active-low. All outputs go to 0.
- Synchronizer flops reset to 1. Symbol buffer, word tracker and counter clear. FSM enters WAIT_LOW.

Synchronizer:
- sig_in passes through a 2-flop synchronizer to produce sig_s (2-cycle latency).
- All durations below are in sig_s samples.

Counter:
- cnt increments by 1 each cycle and saturates at 2^CNT_W-1.
- cnt is cleared to 1 on every state entry listed below, so cnt equals the number of samples spent in the current level.

FSM states and transitions:
- WAIT_LOW: when sig_s=0, go to IDLE. Used after reset and after an over-long mark.
- IDLE: symbol buffer is empty. sig_s=1 goes to MARK, recording prev=IDLE.
- MARK (counting high samples D):
  - If D reaches ON_MAX_CYC: err pulse, clear buffer and word tracker, go to WAIT_LOW.
  - On sig_s=0 with D<GLITCH_CYC: discard the mark and return to prev with cnt restarted.
  - On sig_s=0 with buffer length 5: err pulse, clear buffer and word tracker, go to IDLE.
  - Otherwise: append a dash if D≥DASH_MIN_CYC, else a dot; increment length; go to SPACE.
- SPACE (counting low samples):
  - sig_s=1 goes to MARK (prev=SPACE).
  - When cnt reaches LETTER_GAP_CYC: in the next cycle pulse letter_valid, load letter_bits and letter_len from the buffer, update the word tracker, clear the buffer, and go to GAP (cnt continues, not cleared).
- GAP:
  - sig_s=1 goes to MARK (prev=GAP); a new letter starts in the same word.
  - When cnt reaches WORD_GAP_CYC: in the next cycle pulse sos_detect iff word_ok and nletters==3; clear the tracker; go to IDLE.

Word tracker:
- nletters is a saturating count (0..4).
- word_ok is set at word start. It clears on any letter that does not match the expected letter at its index: S (bits 00000, len 3), then O (bits 00111, len 3), then S. It also clears on a 4th letter.

Pulse rules:
- letter_valid, sos_detect and err are never asserted for more than one cycle.
- letter_valid and sos_detect can never coincide, since they fire from different states.

Reset mid-operation:
- Partial letters and words are discarded. No output pulses occur until sig_s has been seen low.

Decomposition:
- Shared package morse_pkg holds:
  - state encoding (WAIT_LOW, IDLE, MARK, SPACE, GAP);
  - letter constants S_BITS=5'b00000, O_BITS=5'b00111, LEN_S_O=3;
  - default timing constants, derived from QUARTER_CYC=12_500_000 and shared with the blinker.
- One natural sub-module: sync_2ff, a 2-flop synchronizer with a reset-value parameter.

Test Plan:
Benches override parameters to GLITCH=2, DASH_MIN=12, ON_MAX=32, LETTER_GAP=16, WORD_GAP=32, with a dot of 8 high, a dash of 16 high, and intra gap 8, letter gap 24 and word gap 40 low.

1. Drive SOS at these timings -> three letter_valid pulses with bits/len 00000/3, 00111/3, 00000/3; a single sos_detect pulse 33 samples after the final falling edge; err stays 0.
2. During an intra-letter space, a 1-cycle sig_in high -> no symbol appended, no err, and the letter still decodes as S.
3. sig_in held high for 40 cycles -> err pulse when D=32, busy stays high until sig_in is low, no letter_valid; a following S decodes as 00000/3.
4. Six dots with 8-cycle gaps -> err pulse at the 6th falling edge (+2 sync), no letter_valid; FSM returns to IDLE.
5. Drive S,O,S,S then a word gap -> four letter_valid pulses, no sos_detect. Drive S,O,E then a word gap -> E=00000/1, no sos_detect.
6. Assert rst_n low after two dots while sig_in=1, then release -> all outputs 0, FSM stays in WAIT_LOW until sig_in falls; a subsequent SOS yields exactly one sos_detect.
